// File: rtl/me_mem_loader_pkg.sv
// Shared types and sizes for the motion-estimation memory loader.
package me_mem_loader_pkg;
    localparam int PIX_W      = 8;
    localparam int REF_DEPTH  = 256;
    localparam int SRCH_DEPTH = 1024;
    localparam int REF_AW     = 8;
    localparam int SRCH_AW    = 10;
    localparam int SCNT_W     = 13;
    localparam int MV_W       = 4;

    typedef enum logic [2:0] {
        LOAD_R,
        LOAD_S,
        START,
        SEARCH,
        RESULT
    } state_t;
endpackage

// File: rtl/me_mem_loader_if.sv
// Pixel stream in, motion result out: the two handshakes of the loader.
interface me_mem_loader_if;
    import me_mem_loader_pkg::*;

    logic [PIX_W-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [MV_W-1:0]  result_mx;
    logic [MV_W-1:0]  result_my;
    logic [PIX_W-1:0] result_dist;
    logic             result_valid;
    logic             result_ready;

    modport master (
        output in_data, in_valid, result_ready,
        input  in_ready, result_mx, result_my, result_dist, result_valid
    );

    modport slave (
        input  in_data, in_valid, result_ready,
        output in_ready, result_mx, result_my, result_dist, result_valid
    );
endinterface

// File: rtl/me_byte_ram.sv
// Byte-wide RAM: one synchronous write port, RD_PORTS combinational read ports.
module me_byte_ram #(
    parameter int DEPTH    = 256,
    parameter int DATA_W   = 8,
    parameter int RD_PORTS = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                               clock,
    input  logic                               we,
    input  logic [AW-1:0]                      waddr,
    input  logic [DATA_W-1:0]                  wdata,
    input  logic [RD_PORTS-1:0][AW-1:0]        raddr,
    output logic [RD_PORTS-1:0][DATA_W-1:0]    rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; a new frame simply overwrites them.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    for (genvar i = 0; i < RD_PORTS; i++) begin : gRead
        assign rdata[i] = mem[raddr[i]];
    end
endmodule

// File: rtl/me_mem_loader.sv
// Loads a reference and a search window from a byte stream, kicks the estimator,
// and holds its motion-vector result until the consumer takes it.
module me_mem_loader
    import me_mem_loader_pkg::*;
#(
    parameter int SEARCH_CYCLES = 4112
) (
    input  logic                clock,
    input  logic                reset_n,
    me_mem_loader_if.slave      bus,
    output logic                start,
    input  logic [REF_AW-1:0]   AddressR,
    input  logic [SRCH_AW-1:0]  AddressS1,
    input  logic [SRCH_AW-1:0]  AddressS2,
    output logic [PIX_W-1:0]    R,
    output logic [PIX_W-1:0]    s1,
    output logic [PIX_W-1:0]    s2,
    input  logic [MV_W-1:0]     motionx,
    input  logic [MV_W-1:0]     motiony,
    input  logic [PIX_W-1:0]    BestDist,
    output logic                busy
);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SEARCH_CYCLES - 1);

    state_t               state, stateNext;
    logic [SRCH_AW-1:0]   wcnt, wcntNext;
    logic [SCNT_W-1:0]    scnt, scntNext;
    logic                 accept, capture;
    logic                 resValid;
    logic [MV_W-1:0]      resMx, resMy;
    logic [PIX_W-1:0]     resDist;
    logic                 refWe, srchWe;
    logic [1:0][SRCH_AW-1:0] srchRaddr;
    logic [1:0][PIX_W-1:0]   srchRdata;

    assign bus.in_ready = (state == LOAD_R) || (state == LOAD_S);
    assign accept       = bus.in_valid && bus.in_ready;
    assign start        = (state == START);
    assign busy         = (state == START) || (state == SEARCH);

    always_comb begin
        stateNext = state;
        wcntNext  = wcnt;
        scntNext  = scnt;
        capture   = 1'b0;
        case (state)
            LOAD_R: if (accept) begin
                if (wcnt[REF_AW-1:0] == '1) begin
                    wcntNext  = '0;
                    stateNext = LOAD_S;
                end else begin
                    wcntNext = wcnt + 10'd1;
                end
            end
            LOAD_S: if (accept) begin
                if (wcnt == '1) begin
                    wcntNext  = '0;
                    stateNext = START;
                end else begin
                    wcntNext = wcnt + 10'd1;
                end
            end
            START: begin
                scntNext  = '0;
                stateNext = SEARCH;
            end
            SEARCH: begin
                scntNext = scnt + 13'd1;
                if (scnt == SCNT_LAST) begin
                    capture   = 1'b1;
                    stateNext = RESULT;
                end
            end
            RESULT: if (bus.result_ready) stateNext = LOAD_R;
            default: stateNext = LOAD_R;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= LOAD_R;
            wcnt     <= '0;
            scnt     <= '0;
            resValid <= 1'b0;
            resMx    <= '0;
            resMy    <= '0;
            resDist  <= '0;
        end else begin
            state <= stateNext;
            wcnt  <= wcntNext;
            scnt  <= scntNext;
            if (capture) begin
                resValid <= 1'b1;
                resMx    <= motionx;
                resMy    <= motiony;
                resDist  <= BestDist;
            end else if ((state == RESULT) && bus.result_ready) begin
                resValid <= 1'b0;
            end
        end
    end

    assign bus.result_valid = resValid;
    assign bus.result_mx    = resMx;
    assign bus.result_my    = resMy;
    assign bus.result_dist  = resDist;

    // Writes only happen in the load states, so they never overlap estimator reads.
    assign refWe     = accept && (state == LOAD_R);
    assign srchWe    = accept && (state == LOAD_S);
    assign srchRaddr = {AddressS2, AddressS1};
    assign s1        = srchRdata[0];
    assign s2        = srchRdata[1];

    me_byte_ram #(.DEPTH(REF_DEPTH), .DATA_W(PIX_W), .RD_PORTS(1)) refRam (
        .clock (clock),
        .we    (refWe),
        .waddr (wcnt[REF_AW-1:0]),
        .wdata (bus.in_data),
        .raddr (AddressR),
        .rdata (R)
    );

    me_byte_ram #(.DEPTH(SRCH_DEPTH), .DATA_W(PIX_W), .RD_PORTS(2)) srchRam (
        .clock (clock),
        .we    (srchWe),
        .waddr (wcnt),
        .wdata (bus.in_data),
        .raddr (srchRaddr),
        .rdata (srchRdata)
    );
endmodule

// File: tb/tb_me_mem_loader.sv
// Scoreboard bench for me_mem_loader: frame loads, memory readback, result handshake, reset.
module tb_me_mem_loader;
    import me_mem_loader_pkg::*;

    localparam int SC = 16;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    me_mem_loader_if bus();
    logic       start, busy;
    logic [7:0] AddressR;
    logic [9:0] AddressS1, AddressS2;
    logic [7:0] R, s1, s2;
    logic [3:0] motionx, motiony;
    logic [7:0] BestDist;

    me_mem_loader #(.SEARCH_CYCLES(SC)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .start     (start),
        .AddressR  (AddressR),
        .AddressS1 (AddressS1),
        .AddressS2 (AddressS2),
        .R         (R),
        .s1        (s1),
        .s2        (s2),
        .motionx   (motionx),
        .motiony   (motiony),
        .BestDist  (BestDist),
        .busy      (busy)
    );

    int errors = 0;
    int checks = 0;
    int startCount = 0;
    int idleBad = 0;
    int earlyStart = 0;
    logic [15:0] resQ[$];
    logic [7:0]  rdQ[$];

    always @(negedge clock) if (start === 1'b1) startCount <= startCount + 1;

    function automatic logic [7:0] refPat(input int mode, input int i);
        case (mode)
            1:       return 8'(i ^ 'h5A);
            2:       return 8'(i + 1);
            default: return 8'(i);
        endcase
    endfunction

    function automatic logic [7:0] srchPat(input int mode, input int j);
        case (mode)
            1:       return 8'((j * 3) % 256);
            2:       return 8'((j + 7) % 256);
            default: return 8'(j % 256);
        endcase
    endfunction

    // Streams count bytes of pattern mode; returns right after the last byte is accepted-on-next-edge.
    task automatic loadBytes(input int mode, input int count, input bit toggle);
        for (int k = 0; k < count; k++) begin
            logic [7:0] v;
            bit done;
            int guard;
            v = (k < 256) ? refPat(mode, k) : srchPat(mode, k - 256);
            done = 0;
            guard = 0;
            while (!done && guard < 50) begin
                @(negedge clock);
                if (start === 1'b1) earlyStart++;
                if (toggle && ($urandom_range(0, 1) == 1)) begin
                    bus.in_valid = 1'b0;
                    if (bus.in_ready !== 1'b1) idleBad++;
                end else begin
                    bus.in_data  = v;
                    bus.in_valid = 1'b1;
                    if (bus.in_ready === 1'b1) done = 1;
                    else idleBad++;
                end
                guard++;
            end
            if (!done) begin
                $display("FAIL load_timeout byte=%0d in_ready=%b required 1", k, bus.in_ready);
                errors++;
                checks++;
                return;
            end
        end
    endtask

    task automatic checkReads(input logic [7:0] ar, input logic [9:0] a1, input logic [9:0] a2,
                              input logic [7:0] eR, input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0] exp;
        AddressR = ar; AddressS1 = a1; AddressS2 = a2;
        rdQ.push_back(eR); rdQ.push_back(e1); rdQ.push_back(e2);
        #1;
        exp = rdQ.pop_front(); checks++;
        if (R !== exp) begin errors++; $display("FAIL read_R addr=%0d got %h want %h", ar, R, exp); end
        exp = rdQ.pop_front(); checks++;
        if (s1 !== exp) begin errors++; $display("FAIL read_s1 addr=%0d got %h want %h", a1, s1, exp); end
        exp = rdQ.pop_front(); checks++;
        if (s2 !== exp) begin errors++; $display("FAIL read_s2 addr=%0d got %h want %h", a2, s2, exp); end
    endtask

    // Waits for result_valid; optionally checks latency from the start negedge, then scoreboards values.
    task automatic waitResult(input bit checkLat, output bit got);
        int n;
        logic [15:0] exp;
        got = 0;
        for (n = 1; n <= 200; n++) begin
            @(negedge clock);
            if (bus.result_valid === 1'b1) begin got = 1; break; end
        end
        if (!got) begin
            errors++; checks++;
            $display("FAIL result_timeout result_valid=%b required 1", bus.result_valid);
            return;
        end
        if (checkLat) begin
            checks++;
            if (n != SC + 1) begin errors++; $display("FAIL result_latency got %0d want %0d", n, SC + 1); end
        end
        exp = resQ.pop_front();
        checks++;
        if ({bus.result_mx, bus.result_my, bus.result_dist} !== exp) begin
            errors++;
            $display("FAIL result_values got %h/%h/%h want %h/%h/%h", bus.result_mx, bus.result_my,
                     bus.result_dist, exp[15:12], exp[11:8], exp[7:0]);
        end
    endtask

    task automatic ackResult();
        @(negedge clock);
        bus.result_ready = 1'b1;
        @(negedge clock);
        bus.result_ready = 1'b0;
        checks++;
        if (bus.result_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL result_ack valid=%b in_ready=%b busy=%b want 0/1/0",
                     bus.result_valid, bus.in_ready, busy);
        end
    endtask

    task automatic checkStartCycle(input string name);
        @(negedge clock);
        bus.in_valid = 1'b0;
        checks++;
        if (start !== 1'b1 || busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s start=%b busy=%b in_ready=%b want 1/1/0", name, start, busy, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (bus.in_ready !== 1'b1 || start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl in_ready=%b start=%b busy=%b want 1/0/0", bus.in_ready, start, busy);
        end
        checks++;
        if (bus.result_valid !== 1'b0 || bus.result_mx !== 4'd0 || bus.result_my !== 4'd0 ||
            bus.result_dist !== 8'd0) begin
            errors++;
            $display("FAIL reset_result valid=%b mx=%h my=%h dist=%h want all 0", bus.result_valid,
                     bus.result_mx, bus.result_my, bus.result_dist);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_load_basic();
        bit got;
        motionx = 4'd3; motiony = 4'd12; BestDist = 8'h2A;
        resQ.push_back({4'd3, 4'd12, 8'h2A});
        loadBytes(0, 1280, 0);
        checkStartCycle("start_after_last");
        checkReads(8'd17, 10'd700, 10'd255, 8'd17, 8'd188, 8'd255);
        waitResult(1, got);
    endtask

    task automatic test_result_hold();
        int bad = 0;
        motionx = 4'd0; motiony = 4'd0; BestDist = 8'h00;
        bus.result_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (bus.result_valid !== 1'b1 || bus.in_ready !== 1'b0 || busy !== 1'b0 ||
                {bus.result_mx, bus.result_my, bus.result_dist} !== {4'd3, 4'd12, 8'h2A}) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL result_hold unstable cycles=%0d want 0", bad); end
        ackResult();
        checks++;
        if (startCount !== 1) begin errors++; $display("FAIL start_once got %0d want 1", startCount); end
    endtask

    task automatic test_toggle_load();
        int base, bad;
        bit got;
        base = startCount; idleBad = 0; earlyStart = 0; bad = 0;
        loadBytes(1, 1280, 1);
        checks++;
        if (idleBad != 0) begin errors++; $display("FAIL toggle_in_ready bad=%0d want 0", idleBad); end
        checks++;
        if (earlyStart != 0) begin errors++; $display("FAIL early_start got %0d want 0", earlyStart); end
        checkStartCycle("toggle_start");
        motionx = 4'd5; motiony = 4'd9; BestDist = 8'h11;
        resQ.push_back({4'd5, 4'd9, 8'h11});
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            bus.in_valid = 1'b1; bus.in_data = 8'hFF; bus.result_ready = 1'b1;
            if (busy !== 1'b1 || bus.in_ready !== 1'b0) bad++;
        end
        @(negedge clock);
        bus.in_valid = 1'b0; bus.result_ready = 1'b0;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL search_ignore bad=%0d want 0", bad); end
        checkReads(8'd17, 10'd700, 10'd1023, 8'h4B, 8'd52, 8'd253);
        checkReads(8'd0, 10'd0, 10'd256, 8'h5A, 8'd0, 8'd0);
        waitResult(0, got);
        if (got) ackResult();
        checks++;
        if (startCount !== base + 1) begin
            errors++; $display("FAIL toggle_start_once got %0d want %0d", startCount - base, 1);
        end
    endtask

    task automatic test_reset_mid_load();
        int base;
        bit got;
        loadBytes(2, 856, 0);
        @(negedge clock);
        bus.in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0 || start !== 1'b0) begin
            errors++;
            $display("FAIL midload_reset in_ready=%b busy=%b start=%b want 1/0/0", bus.in_ready, busy, start);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        base = startCount; earlyStart = 0;
        loadBytes(2, 1280, 0);
        checkStartCycle("reload_start");
        checks++;
        if (earlyStart != 0) begin errors++; $display("FAIL reload_early_start got %0d want 0", earlyStart); end
        checkReads(8'd0, 10'd0, 10'd1023, 8'd1, 8'd7, 8'd6);
        checkReads(8'd255, 10'd600, 10'd599, 8'd0, 8'd95, 8'd94);
        motionx = 4'd15; motiony = 4'd0; BestDist = 8'hFF;
        resQ.push_back({4'd15, 4'd0, 8'hFF});
        waitResult(0, got);
        if (got) ackResult();
        checks++;
        if (startCount !== base + 1) begin
            errors++; $display("FAIL reload_start_once got %0d want %0d", startCount - base, 1);
        end
    endtask

    initial begin
        bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.result_ready = 1'b0;
        AddressR = '0; AddressS1 = '0; AddressS2 = '0;
        motionx = '0; motiony = '0; BestDist = '0;
        test_reset();
        test_load_basic();
        test_result_hold();
        test_toggle_load();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
